// File: rtl/sram_req_arbiter_pkg.sv
// rtl/sram_req_arbiter_pkg.sv - shared constants for the sram request arbiter
package sram_req_arbiter_pkg;

    // Transfer size encodings on the sram-like interfaces
    localparam logic [1:0] SRAM_SIZE_B = 2'b00;
    localparam logic [1:0] SRAM_SIZE_H = 2'b01;
    localparam logic [1:0] SRAM_SIZE_W = 2'b10;

    // Owner tag stored per outstanding transaction
    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

endpackage

// File: rtl/sram_req_arbiter_owner_fifo.sv
// rtl/sram_req_arbiter_owner_fifo.sv - 1-bit owner FIFO tracking outstanding transactions
//
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   push, din      write one owner tag (caller never pushes when full unless popping)
//   pop            drop the head entry (ignored when empty)
//   head           owner tag of the oldest outstanding transaction
//   count          number of stored entries
//   full, empty    occupancy flags
module sram_req_arbiter_owner_fifo #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             din,
    output logic             head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] mem;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty  = (count == '0);
    assign full   = (count == CNT_W'(DEPTH));
    assign head   = mem[rd_ptr];
    assign do_pop = pop & ~empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // On a full push+pop both pointers sit on the same slot; head was
            // already consumed combinationally, so overwriting it is safe.
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_req_arbiter.sv
// rtl/sram_req_arbiter.sv - shares one sram-like memory port between inst and data requesters
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   inst_sram_*                instruction-fetch requester (req/wr/size/wstrb/addr/wdata in,
//                              addr_ok/data_ok/rdata out)
//   data_sram_*                load/store requester, same shape as inst_sram_*
//   mem_*                      downstream request (out) and addr_ok/data_ok/rdata (in)
//   proto_err                  sticky: mem_data_ok seen with nothing outstanding
module sram_req_arbiter
    import sram_req_arbiter_pkg::*;
#(
    parameter int MAX_OUT = 2,
    parameter int CNT_W   = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output logic        proto_err
);

    logic             lock;
    logic             gnt_reg;
    logic             gnt_d;
    logic             gnt_i;
    logic             can_issue;
    logic             push;
    logic             pop;
    logic             head;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             proto_err_q;

    // A response arriving while full frees a slot for a same-cycle issue
    assign can_issue = (count < CNT_W'(MAX_OUT)) | (mem_data_ok & full);

    // Data side wins when free; once a request is stalled on mem_addr_ok the
    // grant is frozen so the downstream request cannot change under it.
    always_comb begin
        gnt_d = 1'b0;
        gnt_i = 1'b0;
        if (lock) begin
            gnt_d = (gnt_reg == OWNER_DATA);
            gnt_i = (gnt_reg == OWNER_INST);
        end else begin
            gnt_d = data_sram_req;
            gnt_i = inst_sram_req & ~data_sram_req;
        end
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        mem_size  = 2'b00;
        mem_wstrb = 4'h0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        if (!reset) begin
            if (gnt_d) begin
                mem_req   = can_issue & data_sram_req;
                mem_wr    = data_sram_wr;
                mem_size  = data_sram_size;
                mem_wstrb = data_sram_wstrb;
                mem_addr  = data_sram_addr;
                mem_wdata = data_sram_wdata;
            end else if (gnt_i) begin
                mem_req   = can_issue & inst_sram_req;
                mem_wr    = inst_sram_wr;
                mem_size  = inst_sram_size;
                mem_wstrb = inst_sram_wstrb;
                mem_addr  = inst_sram_addr;
                mem_wdata = inst_sram_wdata;
            end
        end
    end

    assign push = mem_req & mem_addr_ok;
    assign pop  = ~reset & mem_data_ok & ~empty;

    assign inst_sram_addr_ok = push & gnt_i;
    assign data_sram_addr_ok = push & gnt_d;
    assign inst_sram_data_ok = pop & (head == OWNER_INST);
    assign data_sram_data_ok = pop & (head == OWNER_DATA);
    assign inst_sram_rdata   = reset ? 32'h0 : mem_rdata;
    assign data_sram_rdata   = reset ? 32'h0 : mem_rdata;
    assign proto_err         = proto_err_q;

    sram_req_arbiter_owner_fifo #(
        .DEPTH (MAX_OUT),
        .CNT_W (CNT_W)
    ) u_owner_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (gnt_d ? OWNER_DATA : OWNER_INST),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock        <= 1'b0;
            gnt_reg     <= OWNER_INST;
            proto_err_q <= 1'b0;
        end else begin
            // Lock only survives while a granted request is still unaccepted;
            // a dropped req lowers mem_req and so releases it.
            lock <= mem_req & ~mem_addr_ok;
            if (mem_req & ~mem_addr_ok) begin
                gnt_reg <= gnt_d ? OWNER_DATA : OWNER_INST;
            end
            if (mem_data_ok & empty) begin
                proto_err_q <= 1'b1;
            end
        end
    end

endmodule
